// File: rtl/onehot8_to_bin_enc_if.sv
// onehot8_to_bin_enc_if
//   Valid/ready bus for the 8-to-3 one-hot encoder.
//   Upstream side:   in_valid, in_onehot -> encoder; in_ready <- encoder
//   Downstream side: out_valid, out_code, out_err <- encoder; out_ready -> encoder
//   master: the agent that feeds words and consumes results (bench / parent)
//   slave:  the encoder itself
interface onehot8_to_bin_enc_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_onehot;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_err;

  modport master (
    output in_valid,
    output in_onehot,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_code,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_onehot,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_code,
    output out_err
  );
endinterface

// File: rtl/onehot8_to_bin_enc.sv
// onehot8_to_bin_enc
//   Registered 8-to-3 encoder. Takes an 8-bit one-hot word over valid/ready
//   and returns its binary index one cycle later from a single output
//   register stage. Zero or multi-hot words are flagged with out_err; for
//   multi-hot words the index of the highest set bit is returned.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      onehot8_to_bin_enc_if.slave (in_valid/in_ready/in_onehot,
//            out_valid/out_ready/out_code/out_err)
//   cnt_clr  synchronous clear of err_cnt (wins over an increment)
//   err_cnt  saturating count of accepted erroneous words
//
// Build option
//   ONEHOT_ERR_CNT_EN  defined: error counter present.
//                      undefined: err_cnt tied to 0, cnt_clr ignored.
//
// Output stage FSM (state register is out_valid)
//   state | meaning
//   EMPTY | no result held; in_ready=1
//   FULL  | result held in out_code/out_err; waits for out_ready
module onehot8_to_bin_enc #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot8_to_bin_enc_if.slave  bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       accept;
  logic [2:0] enc_code;
  logic       enc_err;
  logic [2:0] code_q;
  logic       err_q;

  assign bus.in_ready  = (state == EMPTY) | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_code  = code_q;
  assign bus.out_err   = err_q;

  // Ascending scan: the last hit wins, giving the highest set bit for
  // multi-hot words and 0 for the all-zero word.
  always_comb begin
    enc_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.in_onehot[i]) enc_code = 3'(i);
    end
    // x & (x-1) clears the lowest set bit; non-zero leftover means multi-hot.
    enc_err = (bus.in_onehot == 8'h00) |
              ((bus.in_onehot & (bus.in_onehot - 8'd1)) != 8'h00);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (bus.out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Result registers load only on accept and otherwise hold, also after the
  // result has drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= 3'd0;
      err_q  <= 1'b0;
    end else if (accept) begin
      code_q <= enc_code;
      err_q  <= enc_err;
    end
  end

`ifdef ONEHOT_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (accept && enc_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign err_cnt        = '0;
`endif

endmodule
